dm_hart_ctrl: RTL and testbench

//  Debug-module-side controller that sequences the HART debug interface.

---
 rtl/dm_hart_ctrl.sv | 169 ++++++++++++++++
 tb/tb_dm_hart_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dm_hart_ctrl.sv
// Debug-module hart controller: halt/resume handshake and abstract CSR access sequencing.
// Latency: command accept -> rsp_valid_o is 2 cycles for a CSR access and 1 cycle for a rejected command.
// Backpressure: cmd_ready_o is high only in RUNNING/HALTED; halt/resume ack waits are bounded by ACK_TIMEOUT.
module dm_hart_ctrl #(
   parameter int          ACK_TIMEOUT = 255,
   parameter logic [15:0] CSR_LO      = 16'h07B0,
   parameter logic [15:0] CSR_HI      = 16'h07B2
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        haltreq_i,
   input  logic        resumereq_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_write_i,
   input  logic [15:0] cmd_regno_i,
   input  logic [31:0] cmd_wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic [2:0]  rsp_err_o,
   output logic        halted_o,
   output logic        running_o,
   output logic        busy_o,
   output logic        hart_halt_req_o,
   output logic        hart_rd_wr_en_o,
   output logic        hart_rd_wr_o,
   output logic [15:0] hart_rd_wr_address_o,
   inout  wire  [31:0] hart_rd_wr_data_io,
   input  logic        hart_halt_ack_i,
   input  logic        hart_resume_ack_i,
   input  logic        hart_ebreak_i
);

   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX = TW'(ACK_TIMEOUT);

   typedef enum logic [2:0] {
      RUNNING  = 3'd0,
      HALTING  = 3'd1,
      HALTED   = 3'd2,
      ACCESS   = 3'd3,
      RESUMING = 3'd4
   } state_t;

   state_t        state, state_nxt;
   logic [TW-1:0] timer;
   logic          timeout_flag;
   logic          resume_pend;
   logic          acc_write;
   logic [15:0]   acc_regno;
   logic [31:0]   acc_wdata;

   logic          accept;
   logic          in_range;
   logic          timed_out;
   logic          rsp_set;
   logic [2:0]    rsp_code;
   logic          latch_cmd;
   logic          pend_set;
   logic          pend_clr;

   assign accept    = cmd_valid_i && cmd_ready_o;
   assign in_range  = (cmd_regno_i >= CSR_LO) && (cmd_regno_i <= CSR_HI);
   assign timed_out = (timer == TMAX);

   // Moore status/handshake outputs decoded from the current state
   assign cmd_ready_o          = (state == RUNNING) || (state == HALTED);
   assign running_o            = (state == RUNNING);
   assign halted_o             = (state == HALTED);
   assign busy_o               = !((state == RUNNING) || (state == HALTED));
   assign hart_halt_req_o      = (state == HALTING) || (state == HALTED) || (state == ACCESS);
   assign hart_rd_wr_en_o      = (state == ACCESS);
   assign hart_rd_wr_o         = (state == ACCESS) && acc_write;
   assign hart_rd_wr_address_o = (state == ACCESS) ? acc_regno : 16'h0000;
   // Drive the shared bus only for a write access so a hart read drive never contends
   assign hart_rd_wr_data_io   = ((state == ACCESS) && acc_write) ? acc_wdata : 'z;

   // Next-state decode plus response/latch strobes
   always_comb begin
      state_nxt = state;
      rsp_set   = 1'b0;
      rsp_code  = 3'd0;
      latch_cmd = 1'b0;
      pend_set  = 1'b0;
      pend_clr  = 1'b0;
      unique case (state)
         RUNNING: begin
            if (accept) begin
               rsp_set  = 1'b1;
               rsp_code = 3'd4;
            end
            if (haltreq_i || hart_ebreak_i) state_nxt = HALTING;
         end
         HALTING: begin
            if (hart_halt_ack_i)  state_nxt = HALTED;
            else if (timed_out)   state_nxt = RUNNING;
         end
         HALTED: begin
            if (accept) begin
               // A command beats a simultaneous resume; the resume waits for HALTED again
               pend_set = resumereq_i;
               if (in_range) begin
                  latch_cmd = 1'b1;
                  state_nxt = ACCESS;
               end else begin
                  rsp_set  = 1'b1;
                  rsp_code = 3'd2;
               end
            end else if (resumereq_i || resume_pend) begin
               pend_clr  = 1'b1;
               state_nxt = RESUMING;
            end
         end
         ACCESS: begin
            rsp_set   = 1'b1;
            rsp_code  = 3'd0;
            state_nxt = HALTED;
         end
         RESUMING: begin
            if (hart_resume_ack_i) state_nxt = RUNNING;
            else if (timed_out)    state_nxt = HALTED;
         end
         default: state_nxt = RUNNING;
      endcase
   end

   // State register, ack timer, sticky timeout flag and latched command
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state        <= RUNNING;
         timer        <= '0;
         timeout_flag <= 1'b0;
         resume_pend  <= 1'b0;
         acc_write    <= 1'b0;
         acc_regno    <= 16'h0000;
         acc_wdata    <= 32'h0000_0000;
      end else begin
         state <= state_nxt;
         if (state_nxt != state)     timer <= '0;
         else if (!timed_out)        timer <= timer + 1'b1;
         if (((state == HALTING) && !hart_halt_ack_i && timed_out) ||
             ((state == RESUMING) && !hart_resume_ack_i && timed_out))
            timeout_flag <= 1'b1;
         else if (rsp_set)
            timeout_flag <= 1'b0;
         if (pend_set)      resume_pend <= 1'b1;
         else if (pend_clr) resume_pend <= 1'b0;
         if (latch_cmd) begin
            acc_write <= cmd_write_i;
            acc_regno <= cmd_regno_i;
            acc_wdata <= cmd_wdata_i;
         end
      end
   end

   // Response register: one-cycle valid pulse, error and read data held until next response
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         rsp_valid_o <= 1'b0;
         rsp_err_o   <= 3'd0;
         rsp_rdata_o <= 32'h0000_0000;
      end else begin
         rsp_valid_o <= rsp_set;
         if (rsp_set) rsp_err_o <= timeout_flag ? 3'd7 : rsp_code;
         if ((state == ACCESS) && !acc_write) rsp_rdata_o <= hart_rd_wr_data_io;
      end
   end

endmodule

// File: tb/tb_dm_hart_ctrl.sv
// Directed bench for dm_hart_ctrl: halt, CSR write/read, rejects, resume ordering, ack timeout.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that same point.
// The hart model drives the data bus only while a read access is strobed.
module tb_dm_hart_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        haltreq, resumereq, cmd_valid, cmd_ready, cmd_write;
   logic [15:0] cmd_regno;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [2:0]  rsp_err;
   logic        halted, running, busy, halt_req, rd_wr_en, rd_wr;
   logic [15:0] rd_wr_addr;
   wire  [31:0] bus;
   logic        halt_ack, resume_ack, ebreak;
   logic [31:0] hart_val;
   int          checks = 0;
   int          errors = 0;
   int          n;

   assign bus = (rd_wr_en && !rd_wr) ? hart_val : 'z;

   always #5 clk = ~clk;

   dm_hart_ctrl dut (
      .clk_i(clk), .reset_i(rst_n),
      .haltreq_i(haltreq), .resumereq_i(resumereq),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
      .cmd_regno_i(cmd_regno), .cmd_wdata_i(cmd_wdata),
      .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
      .halted_o(halted), .running_o(running), .busy_o(busy),
      .hart_halt_req_o(halt_req), .hart_rd_wr_en_o(rd_wr_en), .hart_rd_wr_o(rd_wr),
      .hart_rd_wr_address_o(rd_wr_addr), .hart_rd_wr_data_io(bus),
      .hart_halt_ack_i(halt_ack), .hart_resume_ack_i(resume_ack), .hart_ebreak_i(ebreak)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; haltreq = 0; resumereq = 0; cmd_valid = 0; cmd_write = 0;
      cmd_regno = 16'h0; cmd_wdata = 32'h0; halt_ack = 0; resume_ack = 0; ebreak = 0;
      hart_val = 32'h0;
      tick(); tick();
      // reset values
      check("rst_running",  32'(running),   32'd1);
      check("rst_halted",   32'(halted),    32'd0);
      check("rst_busy",     32'(busy),      32'd0);
      check("rst_halt_req", 32'(halt_req),  32'd0);
      check("rst_rsp_vld",  32'(rsp_valid), 32'd0);
      check("rst_rdata",    rsp_rdata,      32'h0);
      check("rst_rd_wr_en", 32'(rd_wr_en),  32'd0);
      rst_n = 1'b1;
      tick();

      // command while running: rejected with not-halted, no hart access
      cmd_valid = 1; cmd_write = 0; cmd_regno = 16'h07B1;
      check("run_cmd_ready", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 0;
      check("run_rsp_vld",  32'(rsp_valid), 32'd1);
      check("run_rsp_err",  32'(rsp_err),   32'd4);
      check("run_no_acc",   32'(rd_wr_en),  32'd0);
      tick();
      check("run_rsp_pulse", 32'(rsp_valid), 32'd0);

      // halt request, ack one cycle later
      haltreq = 1;
      tick();
      haltreq = 0;
      check("halting_req",  32'(halt_req), 32'd1);
      check("halting_busy", 32'(busy),     32'd1);
      check("halting_rdy",  32'(cmd_ready), 32'd0);
      halt_ack = 1;
      tick();
      halt_ack = 0;
      check("halted",       32'(halted),   32'd1);
      check("halted_req",   32'(halt_req), 32'd1);

      // CSR write 0x7B2
      cmd_valid = 1; cmd_write = 1; cmd_regno = 16'h07B2; cmd_wdata = 32'h0000_1234;
      tick();
      cmd_valid = 0;
      check("wr_en",    32'(rd_wr_en), 32'd1);
      check("wr_rw",    32'(rd_wr),    32'd1);
      check("wr_addr",  32'(rd_wr_addr), 32'h07B2);
      check("wr_bus",   bus,           32'h0000_1234);
      check("wr_rdy",   32'(cmd_ready), 32'd0);
      tick();
      check("wr_rsp_vld", 32'(rsp_valid), 32'd1);
      check("wr_rsp_err", 32'(rsp_err),   32'd0);
      check("wr_en_off",  32'(rd_wr_en),  32'd0);

      // CSR read 0x7B0, hart drives the bus
      hart_val = 32'h4000_00C3;
      cmd_valid = 1; cmd_write = 0; cmd_regno = 16'h07B0;
      tick();
      cmd_valid = 0;
      check("rd_en",   32'(rd_wr_en), 32'd1);
      check("rd_rw",   32'(rd_wr),    32'd0);
      check("rd_addr", 32'(rd_wr_addr), 32'h07B0);
      tick();
      check("rd_rsp_vld", 32'(rsp_valid), 32'd1);
      check("rd_rdata",   rsp_rdata,      32'h4000_00C3);
      check("rd_rsp_err", 32'(rsp_err),   32'd0);

      // unsupported regno while halted
      cmd_valid = 1; cmd_regno = 16'h0300;
      tick();
      cmd_valid = 0;
      check("bad_rsp_vld", 32'(rsp_valid), 32'd1);
      check("bad_rsp_err", 32'(rsp_err),   32'd2);
      check("bad_no_acc",  32'(rd_wr_en),  32'd0);
      check("bad_halted",  32'(halted),    32'd1);
      check("bad_rdata_hold", rsp_rdata,   32'h4000_00C3);

      // command and resume in the same cycle: access first, then resume
      cmd_valid = 1; cmd_write = 0; cmd_regno = 16'h07B1; resumereq = 1; hart_val = 32'hCAFE_0001;
      tick();
      cmd_valid = 0; resumereq = 0;
      check("cr_acc_en",  32'(rd_wr_en), 32'd1);
      check("cr_acc_req", 32'(halt_req), 32'd1);
      tick();
      check("cr_rsp_vld", 32'(rsp_valid), 32'd1);
      check("cr_rdata",   rsp_rdata,      32'hCAFE_0001);
      check("cr_req_hold", 32'(halt_req), 32'd1);
      tick();
      check("cr_resuming_req",  32'(halt_req), 32'd0);
      check("cr_resuming_busy", 32'(busy),     32'd1);
      resume_ack = 1;
      tick();
      resume_ack = 0;
      check("cr_running", 32'(running), 32'd1);

      // halt ack never arrives: timeout after 256 cycles in HALTING
      haltreq = 1;
      tick();
      haltreq = 0;
      n = 0;
      while (halt_req && n < 400) begin
         n++;
         tick();
      end
      check("to_cycles",  32'(n),       32'd256);
      check("to_running", 32'(running), 32'd1);
      check("to_req_off", 32'(halt_req), 32'd0);
      cmd_valid = 1; cmd_regno = 16'h07B0;
      tick();
      check("to_rsp_err", 32'(rsp_err), 32'd7);
      tick();
      cmd_valid = 0;
      check("to_flag_clr", 32'(rsp_err), 32'd4);

      // ebreak halts, then reset mid-HALTING restores reset values at once
      ebreak = 1;
      tick();
      ebreak = 0;
      check("eb_halting", 32'(halt_req), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_req",     32'(halt_req), 32'd0);
      check("mid_rst_running", 32'(running),  32'd1);
      check("mid_rst_rsp",     32'(rsp_valid), 32'd0);
      check("mid_rst_rdata",   rsp_rdata,     32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
